platform_shim_ccip_tx_buffer: RTL and testbench

Per-channel CCI-P Tx elastic buffer sitting directly downstream of the AFU and upstream of the FIU-facing Tx port. It absorbs AFU requests into a FIFO and drains them only while the FIU's almost-full is deasserted. It generates its own AFU-facing almost-full with configurable slack, so an AFU that overruns almost-full by a few requests never loses traffic. One instance per Tx channel (c0 read, c1 write); the payload is the channel header plus data, flattened.

---
 rtl/platform_shim_ccip_tx_buffer_if.sv | 43 ++++
 rtl/platform_shim_ccip_tx_buffer.sv | 145 ++++++++++++++
 tb/tb_platform_shim_ccip_tx_buffer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/platform_shim_ccip_tx_buffer_if.sv
// -----------------------------------------------------------------------------
// platform_shim_ccip_tx_buffer_if
//   Tx request path through one CCI-P Tx elastic buffer. Carries the AFU-side
//   request/almost-full pair and the FIU-side request/almost-full pair.
//
//   Signals:
//     afu_valid, afu_payload : AFU -> buffer request
//     afu_almFull            : buffer -> AFU almost-full (registered)
//     fiu_valid, fiu_payload : buffer -> FIU request (registered)
//     fiu_almFull            : FIU -> buffer almost-full
//
//   Modports:
//     slave  : the buffer itself
//     master : the surrounding AFU/FIU environment
// -----------------------------------------------------------------------------
interface platform_shim_ccip_tx_buffer_if #(
    parameter int PAYLOAD_WIDTH = 586
);
    logic                     afu_valid;
    logic [PAYLOAD_WIDTH-1:0] afu_payload;
    logic                     afu_almFull;
    logic                     fiu_valid;
    logic [PAYLOAD_WIDTH-1:0] fiu_payload;
    logic                     fiu_almFull;

    modport slave (
        input  afu_valid,
        input  afu_payload,
        output afu_almFull,
        output fiu_valid,
        output fiu_payload,
        input  fiu_almFull
    );

    modport master (
        output afu_valid,
        output afu_payload,
        input  afu_almFull,
        input  fiu_valid,
        input  fiu_payload,
        output fiu_almFull
    );
endinterface

// File: rtl/platform_shim_ccip_tx_buffer.sv
// -----------------------------------------------------------------------------
// platform_shim_ccip_tx_buffer
//   Per-channel CCI-P Tx elastic buffer. Absorbs AFU requests into a FIFO and
//   drains them to the FIU whenever the FIU almost-full is low. Generates its
//   own AFU almost-full with ALM_FULL_SLACK free entries of headroom so an AFU
//   that overruns almost-full by a few requests does not lose traffic.
//
//   Ports:
//     pClk                  : clock
//     pck_cp2af_softReset_n : asynchronous active-low reset
//     tx                    : request path (slave modport), see the interface
//     occupancy             : current entry count
//     overflow              : sticky, a request arrived while full and was lost
//     stat_issued           : requests issued to the FIU (stats build only)
//     stat_max_occ          : occupancy high-water mark (stats build only)
//
//   Build option:
//     PLATFORM_SHIM_CCIP_TX_BUFFER_STATS_EN - when defined, builds the
//     stat_issued / stat_max_occ counters; otherwise both read 0.
// -----------------------------------------------------------------------------
module platform_shim_ccip_tx_buffer #(
    parameter int PAYLOAD_WIDTH  = 586,
    parameter int DEPTH          = 16,
    parameter int ALM_FULL_SLACK = 4
) (
    input  logic                       pClk,
    input  logic                       pck_cp2af_softReset_n,
    platform_shim_ccip_tx_buffer_if.slave tx,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow,
    output logic [31:0]                stat_issued,
    output logic [$clog2(DEPTH):0]     stat_max_occ
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ALM_LVL  = OCC_W'(DEPTH - ALM_FULL_SLACK);

    // Parameter sanity, caught at elaboration.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "platform_shim_ccip_tx_buffer: DEPTH must be a power of 2 and >= 4");
    end
    if (ALM_FULL_SLACK < 1 || ALM_FULL_SLACK > DEPTH - 1) begin : g_bad_slack
        $fatal(1, "platform_shim_ccip_tx_buffer: ALM_FULL_SLACK must be in 1..DEPTH-1");
    end

    logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]         occ_q, occ_d;
    logic                     overflow_q, overflow_d;
    logic                     alm_full_q, alm_full_d;
    logic                     fiu_valid_q, fiu_valid_d;
    logic [PAYLOAD_WIDTH-1:0] fiu_payload_q, fiu_payload_d;

    logic push, pop, full;

    always_comb begin
        full = (occ_q == FULL_LVL);
        // fiu_almFull is used combinationally: assertion in cycle K blocks
        // the pop decision in that same cycle.
        pop  = (occ_q != '0) && !tx.fiu_almFull;
        // A pop frees the slot being written when full, so push+pop at full
        // both succeed (write lands on the entry just read out).
        push = tx.afu_valid && (!full || pop);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end

        overflow_d    = overflow_q || (tx.afu_valid && !push);
        alm_full_d    = (occ_d >= ALM_LVL);
        fiu_valid_d   = pop;
        fiu_payload_d = pop ? mem_q[rd_ptr_q] : fiu_payload_q;
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            overflow_q    <= 1'b0;
            alm_full_q    <= 1'b0;
            fiu_valid_q   <= 1'b0;
            fiu_payload_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            overflow_q    <= overflow_d;
            alm_full_q    <= alm_full_d;
            fiu_valid_q   <= fiu_valid_d;
            fiu_payload_q <= fiu_payload_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge pClk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx.afu_payload;
        end
    end

    assign tx.afu_almFull = alm_full_q;
    assign tx.fiu_valid   = fiu_valid_q;
    assign tx.fiu_payload = fiu_payload_q;
    assign occupancy      = occ_q;
    assign overflow       = overflow_q;

`ifdef PLATFORM_SHIM_CCIP_TX_BUFFER_STATS_EN
    logic [31:0]      issued_q, issued_d;
    logic [OCC_W-1:0] max_occ_q, max_occ_d;

    always_comb begin
        issued_d  = fiu_valid_q ? issued_q + 32'd1 : issued_q;
        // Compare against next occupancy so the mark tracks the register.
        max_occ_d = (occ_d > max_occ_q) ? occ_d : max_occ_q;
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            issued_q  <= '0;
            max_occ_q <= '0;
        end else begin
            issued_q  <= issued_d;
            max_occ_q <= max_occ_d;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_max_occ = max_occ_q;
`else
    assign stat_issued  = '0;
    assign stat_max_occ = '0;
`endif

endmodule

// File: tb/tb_platform_shim_ccip_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_platform_shim_ccip_tx_buffer
//   Self-checking bench: directed scenarios plus randomized traffic, compared
//   cycle by cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_platform_shim_ccip_tx_buffer;
    localparam int PW    = 586;
    localparam int DEPTH = 16;
    localparam int SLACK = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          pClk = 1'b0;
    logic          rst_n = 1'b0;
    logic [OW-1:0] occupancy;
    logic          overflow;
    logic [31:0]   stat_issued;
    logic [OW-1:0] stat_max_occ;

    platform_shim_ccip_tx_buffer_if #(.PAYLOAD_WIDTH(PW)) tx ();

    platform_shim_ccip_tx_buffer #(
        .PAYLOAD_WIDTH (PW),
        .DEPTH         (DEPTH),
        .ALM_FULL_SLACK(SLACK)
    ) dut (
        .pClk                 (pClk),
        .pck_cp2af_softReset_n(rst_n),
        .tx                   (tx),
        .occupancy            (occupancy),
        .overflow             (overflow),
        .stat_issued          (stat_issued),
        .stat_max_occ         (stat_max_occ)
    );

    always #5 pClk = ~pClk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;   // fiu_valid cycles observed on the DUT

    // Reference model state
    logic [PW-1:0] q[$];
    logic          m_fv;
    logic [PW-1:0] m_fp;
    logic          m_af;
    logic          m_ovf;
    int            m_issued;
    int            m_max;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pl();
        logic [19*32-1:0] t;
        for (int i = 0; i < 19; i++) t[i*32 +: 32] = $urandom;
        return t[PW-1:0];
    endfunction

    task automatic model_clear();
        q.delete();
        m_fv = 0; m_fp = '0; m_af = 0; m_ovf = 0; m_issued = 0; m_max = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic v, input logic [PW-1:0] pl, input logic af);
        logic pop, push;
        tx.afu_valid   = v;
        tx.afu_payload = pl;
        tx.fiu_almFull = af;
        pop  = (q.size() != 0) && !af;
        push = v && (q.size() < DEPTH || pop);
        m_issued = m_issued + (m_fv ? 1 : 0);
        m_fv = pop;
        if (pop) m_fp = q.pop_front();
        if (push) q.push_back(pl);
        else if (v) m_ovf = 1;
        m_af = (q.size() >= DEPTH - SLACK);
        if (q.size() > m_max) m_max = q.size();
        @(posedge pClk);
        #1;
        if (tx.fiu_valid) n_out++;
        chk("fiu_valid",   PW'(tx.fiu_valid),   PW'(m_fv));
        chk("fiu_payload", tx.fiu_payload,      m_fp);
        chk("afu_almFull", PW'(tx.afu_almFull), PW'(m_af));
        chk("occupancy",   PW'(occupancy),      PW'(q.size()));
        chk("overflow",    PW'(overflow),       PW'(m_ovf));
`ifdef PLATFORM_SHIM_CCIP_TX_BUFFER_STATS_EN
        chk("stat_issued", PW'(stat_issued),    PW'(m_issued));
        chk("stat_max",    PW'(stat_max_occ),   PW'(m_max));
`else
        chk("stat_issued", PW'(stat_issued),    '0);
        chk("stat_max",    PW'(stat_max_occ),   '0);
`endif
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_fv"},   PW'(tx.fiu_valid),   '0);
        chk({tag, "_fp"},   tx.fiu_payload,      '0);
        chk({tag, "_af"},   PW'(tx.afu_almFull), '0);
        chk({tag, "_occ"},  PW'(occupancy),      '0);
        chk({tag, "_ovf"},  PW'(overflow),       '0);
        chk({tag, "_iss"},  PW'(stat_issued),    '0);
        chk({tag, "_max"},  PW'(stat_max_occ),   '0);
        tx.afu_valid   = 1'b0;
        tx.afu_payload = '0;
        tx.fiu_almFull = 1'b0;
        model_clear();
        @(negedge pClk);
        rst_n = 1'b1;
        @(posedge pClk);
        #1;
    endtask

    initial begin
        logic [PW-1:0] a5;
        int vals_in;
        int cyc;
        tx.afu_valid   = 1'b0;
        tx.afu_payload = '0;
        tx.fiu_almFull = 1'b0;
        model_clear();
        @(posedge pClk);
        #1;
        do_reset("rst0");

        // Single push: 2-cycle latency.
        a5 = PW'(8'hA5);
        step(1'b1, a5, 1'b0);
        chk("single_early", PW'(tx.fiu_valid), '0);
        step(1'b0, '0, 1'b0);
        chk("single_fv",  PW'(tx.fiu_valid), PW'(1));
        chk("single_fp",  tx.fiu_payload,    a5);
        chk("single_occ", PW'(occupancy),    '0);

        // Backpressure: 12 pushes reach the almost-full threshold.
        do_reset("rst1");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, rnd_pl(), 1'b1);
            if (i == 10) chk("bp_af11", PW'(tx.afu_almFull), '0);
        end
        chk("bp_af",  PW'(tx.afu_almFull), PW'(1));
        chk("bp_occ", PW'(occupancy),      PW'(12));
        n_out = 0;
        for (int i = 0; i < 13; i++) step(1'b0, '0, 1'b0);
        chk("bp_drain", PW'(n_out), PW'(12));

        // Overflow: 17th push is dropped.
        do_reset("rst2");
        for (int i = 0; i < 17; i++) step(1'b1, rnd_pl(), 1'b1);
        chk("ovf_flag", PW'(overflow),  PW'(1));
        chk("ovf_occ",  PW'(occupancy), PW'(16));
        n_out = 0;
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b0);
        chk("ovf_drain", PW'(n_out), PW'(16));

        // Full with simultaneous push and pop.
        do_reset("rst3");
        for (int i = 0; i < 16; i++) step(1'b1, rnd_pl(), 1'b1);
        step(1'b1, rnd_pl(), 1'b0);
        chk("fpp_occ", PW'(occupancy), PW'(16));
        chk("fpp_ovf", PW'(overflow),  '0);
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b0);

        // Wrap-around: 0..39 with fiu_almFull toggling every 3 cycles.
        do_reset("rst4");
        vals_in = 0;
        cyc = 0;
        n_out = 0;
        while (vals_in < 40 && cyc < 400) begin
            if (!m_af) begin
                step(1'b1, PW'(vals_in), ((cyc / 3) % 2) == 1);
                vals_in++;
            end else begin
                step(1'b0, '0, ((cyc / 3) % 2) == 1);
            end
            cyc++;
        end
        chk("wrap_all_in", PW'(vals_in), PW'(40));
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0);
        chk("wrap_cnt", PW'(n_out), PW'(40));
`ifdef PLATFORM_SHIM_CCIP_TX_BUFFER_STATS_EN
        chk("wrap_stat", PW'(stat_issued), PW'(40));
`else
        chk("wrap_stat", PW'(stat_issued), '0);
`endif

        // Reset mid-drain with 7 entries held.
        do_reset("rst5");
        for (int i = 0; i < 8; i++) step(1'b1, rnd_pl(), 1'b1);
        step(1'b0, '0, 1'b0);
        chk("mid_occ", PW'(occupancy), PW'(7));
        do_reset("mid_rst");
        n_out = 0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        chk("mid_stale", PW'(n_out), '0);

        // Randomized traffic; the AFU mostly honors almost-full.
        do_reset("rst6");
        for (int i = 0; i < 3000; i++) begin
            logic v;
            v = ($urandom_range(9) < 7) && (!m_af || $urandom_range(3) == 0);
            step(v, rnd_pl(), $urandom_range(9) < 3);
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
